// File: rtl/rr_mux.sv
// N-channel valid/ready mux into a single-entry output register, fixed-select or round-robin.
// One cycle in to out; inputs see ready only while the output slot is empty or draining.
module rr_mux #(
  parameter  int WIDTH = 16,
  parameter  int N     = 4,
  localparam int SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_chan
);

  localparam logic [SELW-1:0] LAST = SELW'(N - 1);

  logic             load_en;
  logic             gnt_vld;
  logic [SELW-1:0]  gnt;
  logic [SELW-1:0]  cand;
  logic [SELW-1:0]  ptr;
  logic [WIDTH-1:0] sel_dat;

  assign load_en = !out_valid || out_ready;

  // Round-robin walks upward from the channel after the last winner; wraps at N-1.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    cand    = ptr;
    if (mode) begin
      for (int k = 0; k < N; k++) begin
        cand = (cand == LAST) ? '0 : cand + 1'b1;
        if (!gnt_vld && in_valid[cand]) begin
          gnt_vld = 1'b1;
          gnt     = cand;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (sel == SELW'(i) && in_valid[i]) begin
          gnt_vld = 1'b1;
          gnt     = SELW'(i);
        end
      end
    end
  end

  always_comb begin
    sel_dat = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt == SELW'(i)) sel_dat = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    in_ready = '0;
    if (rst_n && load_en && gnt_vld) in_ready[gnt] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= LAST;
    end else if (load_en) begin
      out_valid <= gnt_vld;
      if (gnt_vld) begin
        out_data <= sel_dat;
        out_chan <= gnt;
        ptr      <= gnt;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux.sv
// Self-checking bench for rr_mux (WIDTH=16, N=4): directed scenarios plus a randomized run against a reference model.
module tb_rr_mux;

  localparam int WIDTH = 16;
  localparam int N     = 4;

  logic              clk;
  logic              rst_n;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]      in_valid;
  logic [N-1:0]      in_ready;
  logic              mode;
  logic [1:0]        sel;
  logic [WIDTH-1:0]  out_data;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_chan;

  int tests;
  int fails;

  // reference state
  bit              m_vld;
  logic [WIDTH-1:0] m_dat;
  int              m_chan;
  int              m_ptr;

  rr_mux #(.WIDTH(WIDTH), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_chan  (out_chan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void ref_grant(input logic md, input int s, input logic [N-1:0] v,
                                    input int p, output bit found, output int g);
    int idx;
    found = 0;
    g     = 0;
    if (!md) begin
      if (s < N && v[s]) begin
        found = 1;
        g     = s;
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        idx = (p + k) % N;
        if (!found && v[idx]) begin
          found = 1;
          g     = idx;
        end
      end
    end
  endfunction

  function automatic logic [N-1:0] ref_ready(input bit vld, input logic ordy, input bit found, input int g);
    logic [N-1:0] r;
    r = '0;
    if ((!vld || ordy) && found) r[g] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_vld  = 0;
    m_dat  = '0;
    m_chan = 0;
    m_ptr  = N - 1;
  endtask

  task automatic model_clock();
    bit found;
    int g;
    ref_grant(mode, int'(sel), in_valid, m_ptr, found, g);
    if (!m_vld || out_ready) begin
      m_vld = found;
      if (found) begin
        m_dat  = in_data[g*WIDTH +: WIDTH];
        m_chan = g;
        m_ptr  = g;
      end
    end
  endtask

  task automatic set_ch(input int ch, input logic [WIDTH-1:0] d);
    in_data[ch*WIDTH +: WIDTH] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = 1'b0;
    mode      = 1'b0;
    sel       = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    mode      = 1'b1;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    #1;
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    tests++;
    if (out_data !== 16'h0) begin fails++; $display("FAIL reset_out_data got=%h exp=0000", out_data); end
    tests++;
    if (out_chan !== 2'd0) begin fails++; $display("FAIL reset_out_chan got=%0d exp=0", out_chan); end
    tests++;
    if (in_ready !== 4'b0000) begin fails++; $display("FAIL reset_in_ready got=%b exp=0000", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fixed();
    do_reset();
    for (int i = 0; i < N; i++) set_ch(i, 16'h1000 + 16'(i));
    set_ch(2, 16'h5555);
    mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 4'b0100) begin fails++; $display("FAIL fixed_in_ready got=%b exp=0100", in_ready); end
    @(posedge clk); @(negedge clk);
    tests++;
    if (out_valid !== 1'b1 || out_data !== 16'h5555 || out_chan !== 2'd2) begin
      fails++; $display("FAIL fixed_out got=v%b d%h c%0d exp=v1 d5555 c2", out_valid, out_data, out_chan);
    end
    in_valid = 4'b1011;
    #1;
    tests++;
    if (in_ready !== 4'b0000) begin fails++; $display("FAIL fixed_other_valid got=%b exp=0000", in_ready); end
  endtask

  task automatic test_rr_fair();
    do_reset();
    for (int i = 0; i < N; i++) set_ch(i, 16'hA000 + 16'(i));
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); @(negedge clk);
      tests++;
      if (out_valid !== 1'b1 || out_chan !== 2'(c % N) || out_data !== 16'hA000 + 16'(c % N)) begin
        fails++; $display("FAIL rr_fair cycle %0d got=v%b c%0d d%h exp=v1 c%0d d%h",
                          c, out_valid, out_chan, out_data, c % N, 16'hA000 + 16'(c % N));
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_ch(1, 16'h9112);
    mode = 1'b0; sel = 2'd1; in_valid = 4'b0010; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0; mode = 1'b1; in_valid = 4'b1111;
    set_ch(1, 16'h1234); set_ch(2, 16'hBEEF);
    for (int c = 0; c < 3; c++) begin
      #1;
      tests++;
      if (in_ready !== 4'b0000 || out_valid !== 1'b1 || out_data !== 16'h9112 || out_chan !== 2'd1) begin
        fails++; $display("FAIL backpressure cycle %0d got=r%b v%b d%h c%0d exp=r0000 v1 d9112 c1",
                          c, in_ready, out_valid, out_data, out_chan);
      end
      @(posedge clk); @(negedge clk);
      sel = 2'(c);
    end
    out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 4'b0100) begin fails++; $display("FAIL backpressure_release got=%b exp=0100", in_ready); end
    @(posedge clk); @(negedge clk);
    tests++;
    if (out_valid !== 1'b1 || out_data !== 16'hBEEF || out_chan !== 2'd2) begin
      fails++; $display("FAIL backpressure_next got=v%b d%h c%0d exp=v1 dbeef c2", out_valid, out_data, out_chan);
    end
  endtask

  task automatic test_sparse_wrap();
    do_reset();
    for (int i = 0; i < N; i++) set_ch(i, 16'hC000 + 16'(i));
    mode = 1'b1; in_valid = 4'b0100; out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 4'b0100) begin fails++; $display("FAIL sparse_ready got=%b exp=0100", in_ready); end
    @(posedge clk); @(negedge clk);
    in_valid = 4'b0101;
    #1;
    tests++;
    if (in_ready !== 4'b0001) begin fails++; $display("FAIL wrap_ready got=%b exp=0001", in_ready); end
    @(posedge clk); @(negedge clk);
    tests++;
    if (out_chan !== 2'd0 || out_data !== 16'hC000) begin
      fails++; $display("FAIL wrap_out got=c%0d d%h exp=c0 dc000", out_chan, out_data);
    end
  endtask

  task automatic test_invalid_empty();
    do_reset();
    set_ch(1, 16'h7777);
    mode = 1'b0; sel = 2'd1; in_valid = 4'b0010; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 4'b1101;
    #1;
    tests++;
    if (in_ready !== 4'b0000) begin fails++; $display("FAIL invalid_sel_ready got=%b exp=0000", in_ready); end
    @(posedge clk); @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || out_data !== 16'h7777 || out_chan !== 2'd1) begin
      fails++; $display("FAIL empty_drain got=v%b d%h c%0d exp=v0 d7777 c1", out_valid, out_data, out_chan);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < N; i++) set_ch(i, 16'hD000 + 16'(i));
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || out_data !== 16'h0 || out_chan !== 2'd0 || in_ready !== 4'b0000) begin
      fails++; $display("FAIL reset_mid got=v%b d%h c%0d r%b exp=v0 d0000 c0 r0000",
                        out_valid, out_data, out_chan, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1; in_valid = 4'b1010; out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 4'b0010) begin fails++; $display("FAIL reset_mid_ready got=%b exp=0010", in_ready); end
    @(posedge clk); @(negedge clk);
    tests++;
    if (out_valid !== 1'b1 || out_chan !== 2'd1) begin
      fails++; $display("FAIL reset_mid_first got=v%b c%0d exp=v1 c1", out_valid, out_chan);
    end
  endtask

  task automatic test_random();
    bit found;
    int g;
    logic [N-1:0] exp_rdy;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      tests++;
      if (out_valid !== m_vld || (m_vld && (out_data !== m_dat || out_chan !== 2'(m_chan)))) begin
        fails++; $display("FAIL random_out cycle %0d got=v%b d%h c%0d exp=v%b d%h c%0d",
                          c, out_valid, out_data, out_chan, m_vld, m_dat, m_chan);
      end
      in_data   = {$urandom, $urandom};
      in_valid  = 4'($urandom);
      mode      = ($urandom_range(0, 3) != 0);
      sel       = 2'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      ref_grant(mode, int'(sel), in_valid, m_ptr, found, g);
      exp_rdy = ref_ready(m_vld, out_ready, found, g);
      tests++;
      if (in_ready !== exp_rdy) begin
        fails++; $display("FAIL random_ready cycle %0d got=%b exp=%b", c, in_ready, exp_rdy);
      end
      @(posedge clk);
      model_clock();
    end
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b1;
    in_data   = '0;
    in_valid  = '0;
    mode      = 1'b0;
    sel       = '0;
    out_ready = 1'b0;
    model_reset();
    test_reset();
    test_fixed();
    test_rr_fair();
    test_backpressure();
    test_sparse_wrap();
    test_invalid_empty();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
